// File: rtl/rr_outport_allocator.sv
// rtl/rr_outport_allocator.sv - packet-aware round-robin allocator for one mesh-router output port
//
// Shares one output port among five input ports (0=local, 1=N, 2=E, 3=S, 4=W).
// A grant is taken in IDLE and held in BUSY. Each flit is gated on downstream credits.
//
// Optional feature macro: RR_OUTPORT_PKT_LOCK_EN
//   defined   : the grant is held for a whole wormhole packet and released on the tail flit
//   undefined : flit-level round robin, where every transfer releases the grant and tail is ignored
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req[4:0]    input port i has a head-of-line flit for this output
//   tail[4:0]   head-of-line flit of port i is a tail flit (valid with req[i])
//   credit_ret  one-cycle pulse: downstream freed one buffer slot
//   gnt[4:0]    registered one-hot grant (or zero), crossbar select
//   xfer        combinational: a flit crosses the port this cycle
//   credit_cnt  current credit count
//   credit_err  sticky credit-overflow flag, cleared only by rst
module rr_outport_allocator #(
  parameter int NUM_REQ    = 5,
  parameter int CREDIT_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] tail,
  input  logic               credit_ret,
  output logic [NUM_REQ-1:0] gnt,
  output logic               xfer,
  output logic [CNT_W-1:0]   credit_cnt,
  output logic               credit_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [2:0]         ptr, ptr_nxt;
  logic [2:0]         owner, owner_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [2:0]         winner;
  logic               win_vld;
  logic               has_credit;
  logic               arb;
  logic               release_gnt;

  assign has_credit = (credit_cnt != '0);
  assign arb        = (state == IDLE) && win_vld && has_credit;

  // Scan ptr, ptr+1, ... modulo NUM_REQ. The loop runs from the farthest offset
  // down to the nearest, so the nearest requester is the last one assigned.
  always_comb begin
    logic [3:0] sum;
    winner  = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
      if (req[sum[2:0]] == 1'b1) begin
        winner  = sum[2:0];
        win_vld = 1'b1;
      end
    end
  end

  // Only the owner's req/tail bits are looked at in BUSY, so X/Z on other ports stays contained.
  assign xfer = (state == BUSY) && gnt[owner] && req[owner] && has_credit;

`ifdef RR_OUTPORT_PKT_LOCK_EN
  assign release_gnt = xfer && tail[owner];
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign release_gnt = xfer;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb) state_nxt = BUSY;
      BUSY:    if (release_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. ptr only moves on release, which bounds the wait of any requester.
  always_comb begin
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (arb) begin
          gnt_nxt   = NUM_REQ'(1) << winner;
          owner_nxt = winner;
        end
      end
      BUSY: begin
        if (release_gnt) begin
          gnt_nxt = '0;
          ptr_nxt = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  // Credit counter. A return and a transfer in the same cycle cancel each other.
  // A return at full count is an overflow: the count is held and the error latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CNT_W'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else if (xfer && !credit_ret) begin
      credit_cnt <= credit_cnt - CNT_W'(1);
    end else if (credit_ret && !xfer) begin
      if (credit_cnt < CNT_W'(CREDIT_MAX)) credit_cnt <= credit_cnt + CNT_W'(1);
      else credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_outport_allocator.sv
// tb/tb_rr_outport_allocator.sv - self-checking bench for rr_outport_allocator
module tb_rr_outport_allocator;

  localparam int CREDIT_MAX = 4;
`ifdef RR_OUTPORT_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_ret;
  logic [4:0] gnt;
  logic       xfer;
  logic [2:0] credit_cnt;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  // Expected {gnt, xfer, credit_cnt, credit_err} per cycle
  logic [9:0] exp_q[$];

  // Reference model state
  bit         m_busy;
  logic [4:0] m_gnt;
  int         m_owner, m_ptr, m_cnt;
  logic       m_err;

  always #5 clk = ~clk;

  rr_outport_allocator #(.NUM_REQ(5), .CREDIT_MAX(CREDIT_MAX), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_ret(credit_ret),
    .gnt(gnt), .xfer(xfer), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({gnt, xfer, credit_cnt, credit_err} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got gnt=%b xfer=%b cnt=%0d err=%b, expected gnt=%b xfer=%b cnt=%0d err=%b",
                 $time, gnt, xfer, credit_cnt, credit_err, e[9:5], e[4], e[3:1], e[0]);
      end
    end
  end

  function automatic logic model_xfer();
    return m_busy && (req[m_owner] === 1'b1) && (m_cnt != 0);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gnt = '0; m_owner = 0; m_ptr = 0; m_cnt = CREDIT_MAX; m_err = 1'b0;
  endtask

  task automatic model_update(input logic mx);
    int  old_cnt;
    bit  found;
    if (rst) begin
      model_reset();
    end else begin
      old_cnt = m_cnt;
      if (mx && !credit_ret) m_cnt = m_cnt - 1;
      else if (!mx && credit_ret) begin
        if (m_cnt < CREDIT_MAX) m_cnt = m_cnt + 1;
        else m_err = 1'b1;
      end
      if (!m_busy) begin
        found = 0;
        if (req != 5'b0 && old_cnt != 0) begin
          for (int k = 0; k < 5; k++) begin
            if (!found && req[(m_ptr + k) % 5]) begin
              found   = 1;
              m_owner = (m_ptr + k) % 5;
            end
          end
        end
        if (found) begin
          m_busy = 1;
          m_gnt  = 5'b00001 << m_owner;
        end
      end else if (mx && (!LOCK || tail[m_owner])) begin
        m_busy = 0;
        m_gnt  = '0;
        m_ptr  = (m_owner + 1) % 5;
      end
    end
  endtask

  // One clock: push this cycle's expected outputs, advance, update the model.
  task automatic step(output logic mx);
    mx = model_xfer();
    exp_q.push_back({m_gnt, mx, 3'(m_cnt), m_err});
    @(posedge clk);
    model_update(mx);
    #1;
  endtask

  task automatic do_reset();
    logic mx;
    rst = 1; req = '0; tail = '0; credit_ret = 0;
    step(mx);
    rst = 0;
  endtask

  task automatic test_reset();
    logic mx;
    rst = 1; req = 5'b11111; tail = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      credit_ret = (i == 0);
      step(mx);
      checks++;
      if (gnt !== 5'b0 || xfer !== 1'b0 || credit_cnt !== 3'd4 || credit_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_values got gnt=%b xfer=%b cnt=%0d err=%b, expected 00000 0 4 0", gnt, xfer, credit_cnt, credit_err);
      end
    end
    rst = 0; credit_ret = 0;
    step(mx);
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL reset_first_grant got %b expected 00001", gnt);
    end
  endtask

  task automatic test_single_packet();
    logic mx;
    int   sent, cyc;
    do_reset();
    req = 5'b00100; sent = 0; cyc = 0;
    while (sent < 3 && cyc < 20) begin
      tail = (sent == 2) ? 5'b00100 : 5'b0;
      step(mx);
      if (mx) sent++;
      cyc++;
    end
    req = '0; tail = '0;
    checks++;
    if (cyc != (LOCK ? 4 : 6) || gnt !== 5'b0 || credit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_packet got cycles=%0d gnt=%b cnt=%0d, expected cycles=%0d gnt=00000 cnt=1",
               cyc, gnt, credit_cnt, LOCK ? 4 : 6);
    end
    req = 5'b11111; tail = 5'b11111;
    step(mx);
    checks++;
    if (gnt !== 5'b01000) begin
      errors++;
      $display("FAIL single_packet_ptr got %b expected 01000", gnt);
    end
  endtask

  task automatic test_fairness();
    logic       mx;
    logic [4:0] tbl[8];
    tbl = '{5'b00001, 5'b00000, 5'b00100, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};
    do_reset();
    req = 5'b10101; tail = 5'b11111; credit_ret = 1;
    for (int i = 0; i < 8; i++) begin
      step(mx);
      checks++;
      if (gnt !== tbl[i]) begin
        errors++;
        $display("FAIL fairness cycle %0d got %b expected %b", i + 1, gnt, tbl[i]);
      end
    end
    credit_ret = 0;
  endtask

  task automatic test_credit_stall();
    logic mx;
    int   sent, dut_x;
    do_reset();
    req = 5'b00010; sent = 0; dut_x = 0;
    for (int i = 0; i < 10; i++) begin
      tail = (sent == 5) ? 5'b00010 : 5'b0;
      if (xfer === 1'b1) dut_x++;
      step(mx);
      if (mx) sent++;
    end
    checks++;
    if (dut_x != 4 || credit_cnt !== 3'd0 || xfer !== 1'b0 || gnt !== (LOCK ? 5'b00010 : 5'b00000)) begin
      errors++;
      $display("FAIL credit_stall got xfers=%0d cnt=%0d xfer=%b gnt=%b, expected 4 0 0 %b",
               dut_x, credit_cnt, xfer, gnt, LOCK ? 5'b00010 : 5'b00000);
    end
    dut_x = 0;
    credit_ret = 1;
    if (xfer === 1'b1) dut_x++;
    step(mx);
    credit_ret = 0;
    for (int i = 0; i < 4; i++) begin
      if (xfer === 1'b1) dut_x++;
      step(mx);
    end
    checks++;
    if (dut_x != 1 || credit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL credit_stall_resume got xfers=%0d cnt=%0d, expected 1 0", dut_x, credit_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic mx;
    bit   hit;
    int   cyc;
    do_reset();
    req = 5'b00001; tail = '0; hit = 0; cyc = 0;
    while (!hit && cyc < 20) begin
      credit_ret = model_xfer() && (m_cnt == 2);
      step(mx);
      if (credit_ret) begin
        hit = 1;
        checks++;
        if (credit_cnt !== 3'd2) begin
          errors++;
          $display("FAIL simultaneous got cnt=%0d expected 2", credit_cnt);
        end
      end
      cyc++;
    end
    credit_ret = 0;
    if (!hit) begin
      checks++; errors++;
      $display("FAIL simultaneous_timeout got no xfer at cnt=2 within 20 cycles, expected one");
    end
    do_reset();
    credit_ret = 1;
    step(mx);
    credit_ret = 0;
    step(mx);
    checks++;
    if (credit_err !== 1'b1 || credit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL overflow got err=%b cnt=%0d expected 1 4", credit_err, credit_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic mx;
    int   sent, cyc;
    do_reset();
    req = 5'b00010; tail = '0; sent = 0; cyc = 0;
    while (sent < 2 && cyc < 20) begin
      step(mx);
      if (mx) sent++;
      cyc++;
    end
    rst = 1;
    step(mx);
    rst = 0;
    checks++;
    if (gnt !== 5'b0 || credit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL reset_mid got gnt=%b cnt=%0d expected 00000 4", gnt, credit_cnt);
    end
    req = 5'b00011;
    step(mx);
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL reset_mid_winner got %b expected 00001", gnt);
    end
    req = '0;
  endtask

  initial begin
    logic mx;
    rst = 1; req = '0; tail = '0; credit_ret = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_packet();
    test_fairness();
    test_credit_stall();
    test_simultaneous();
    test_reset_mid_packet();
    do_reset();
    step(mx);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_outport_allocator.md
Name: rr_outport_allocator

Overview:
- Packet-aware round-robin allocator for one mesh-router output port. Shares the port among the five input ports: 0 = local, 1 = N, 2 = E, 3 = S, 4 = W.
- Holds the grant for a whole wormhole packet and gates each flit on credits from the downstream input buffer.
- One instance sits per output port, between the input-port request logic and the crossbar select.

Parameters:
- NUM_REQ, 5, number of requesting input ports. Fixed at 5; other values are not supported.
- CREDIT_MAX, 4, depth in flits of the downstream buffer. Also the credit counter reset value. Legal range 1..(2^CNT_W - 1).
- CNT_W, 3, width of the credit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  5  req[i]: input port i has a head-of-line flit destined for this output.
- tail  in  5  tail[i]: the head-of-line flit of port i is a tail flit. Single-flit packets set both head and tail. Valid only while req[i] is high.
- credit_ret  in  1  one-cycle pulse: downstream freed one buffer slot.
- gnt  out  5  registered one-hot grant (or all zero); drives the crossbar select.
- xfer  out  1  combinational; a flit crosses the port this cycle.
- credit_cnt  out  CNT_W  current credit count.
- credit_err  out  1  sticky flag: credit overflow detected.

Behaviour:
- Reset values: state=IDLE, gnt=0, ptr=0, credit_cnt=CREDIT_MAX, credit_err=0. Reset takes priority over every other event, including in the middle of a packet: grant dropped, credits restored.
- Registers: ptr (3 bits, 0..4) is the round-robin start position; owner (3 bits) is the granted port.
- IDLE:
  - Arbitrate only when req!=0 and credit_cnt!=0.
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... modulo 5.
  - Next edge: gnt = one-hot(winner), owner = winner, state=BUSY.
  - gnt is 0 throughout IDLE; grant latency is 1 cycle from the request.
  - With credit_cnt=0: stay in IDLE, no grant.
- BUSY:
  - xfer = gnt[owner] & req[owner] & (credit_cnt!=0).
  - On an edge with xfer=1 and tail[owner]=1: gnt=0, state=IDLE, ptr=(owner+1) mod 5.
  - Otherwise hold owner and gnt (packet lock). This includes req[owner] low mid-packet (bubble) and credit_cnt=0 (stall).
  - Requests from other ports are ignored in BUSY.
- After release, at least one IDLE cycle precedes the next grant, so back-to-back packets have a 1-cycle turnaround. xfer=0 whenever state=IDLE.
- ptr changes only on release. This guarantees each requesting port is served within 4 packets.
- Credit counter, next value:
  - xfer and credit_ret together: unchanged.
  - xfer only: minus 1. xfer cannot occur at 0.
  - credit_ret only: plus 1 when below CREDIT_MAX. At CREDIT_MAX the count is held and credit_err is set to 1, cleared only by rst.
- gnt is never more than one-hot. An X/Z on req or tail while BUSY affects only the owner's bit.

Optional Feature:
- Macro RR_OUTPORT_PKT_LOCK_EN.
- Defined: packet lock as described above; release only on the tail flit.
- Not defined: flit-level round robin. Every xfer releases to IDLE regardless of tail, with ptr=(owner+1) mod 5. The tail input is ignored, and flits of different packets may interleave.

Test Plan:
- Reset values:
  - Stimulus: rst high 2 cycles with req=5'b11111, credit_ret pulses.
  - Required: gnt=0, xfer=0, credit_cnt=4, credit_err=0 throughout. After rst falls, gnt=5'b00001 one cycle later.
- Single 3-flit packet:
  - Stimulus: req=5'b00100, tail high on the 3rd flit only.
  - Required: gnt=5'b00100 from cycle 1; xfer high cycles 1-3; credit_cnt 4→3→2→1; gnt=0 at cycle 4; ptr=3.
- Contention fairness:
  - Stimulus: req=5'b10101 held, single-flit packets, credit_ret every cycle.
  - Required: grant order 0, 2, 4, 0, each grant separated by one IDLE cycle.
- Credit stall:
  - Stimulus: CREDIT_MAX=4, a 6-flit packet, no credit_ret.
  - Required: 4 xfers, then xfer=0 with gnt held. One credit_ret pulse produces exactly one more xfer. credit_cnt never wraps below 0.
- Simultaneous return and transfer:
  - Stimulus: xfer and credit_ret in the same cycle at credit_cnt=2.
  - Required: credit_cnt stays 2. A credit_ret at credit_cnt=4 with no xfer sets credit_err=1, credit_cnt stays 4.
- Reset mid-packet:
  - Stimulus: rst asserted after the 2nd flit of a 4-flit packet from port 1.
  - Required: next cycle gnt=0, credit_cnt=4, ptr=0. With req=5'b00011 afterwards, port 0 wins.
